rd_sched: RTL and testbench

RD_SCHED -- requirements
Module: rd_sched

---
 rtl/rd_sched.sv | 155 +++++++++++++++
 tb/tb_rd_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_sched.sv
// Two-channel round-robin read scheduler that splits transfers into read-block commands.
// Optional macro RD_SCHED_SPLIT_EN: chunk each transfer to at most MAX_CHUNK bytes.
module rd_sched #(
  parameter int MAX_CHUNK = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [15:0] req_size0,
  input  logic [15:0] req_size1,
  output logic [1:0]  grant,
  output logic [1:0]  ch_done,
  output logic        rb_start,
  output logic [31:0] rb_addr,
  output logic [15:0] rb_size,
  input  logic        rb_busy,
  input  logic        rb_done,
  output logic        busy
);

  generate
    if (MAX_CHUNK < 4 || MAX_CHUNK > 32768 || (MAX_CHUNK % 4) != 0) begin : g_bad_cfg
      $error("rd_sched: MAX_CHUNK must be a multiple of 4 in 4..32768");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q, done_d;
  logic        start_q, start_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] size_q, size_d;
  logic [16:0] rem_q, rem_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;   // 1: channel 1 was served last

  logic        pick1;
  logic [31:0] sel_addr;
  logic [15:0] sel_size;
  logic [16:0] step;

`ifdef RD_SCHED_SPLIT_EN
  localparam logic [16:0] CHUNK_CAP = 17'(MAX_CHUNK);

  function automatic logic [16:0] chunk_of(input logic [16:0] rem);
    return (rem > CHUNK_CAP) ? CHUNK_CAP : rem;
  endfunction
`else
  function automatic logic [16:0] chunk_of(input logic [16:0] rem);
    return rem;
  endfunction
`endif

  // A full 64 KiB chunk cannot be expressed in 16 bits; report the largest word-aligned size.
  function automatic logic [15:0] size_of(input logic [16:0] rem);
    logic [16:0] c;
    c = chunk_of(rem);
    return c[16] ? 16'hFFFC : c[15:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = 2'b00;
    start_d  = start_q;
    addr_d   = addr_q;
    size_d   = size_q;
    rem_d    = rem_q;
    last_d   = last_q;
    pick1    = req1 && (!req0 || !last_q);
    sel_addr = pick1 ? req_addr1 : req_addr0;
    sel_size = pick1 ? req_size1 : req_size0;
    step     = chunk_of(rem_q);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = {sel_addr[31:2], 2'b00};
          rem_d   = ({1'b0, sel_size} + 17'd3) & ~17'd3;
          size_d  = size_of(rem_d);
          start_d = (rem_d != 17'd0);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rem_q == 17'd0) begin
          state_d = FIN;
        end else if (rb_busy) begin
          start_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rb_done) begin
          rem_d  = rem_q - step;
          addr_d = addr_q + {15'd0, step};
          size_d = size_of(rem_d);
          if (rem_d != 17'd0) begin
            start_d = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done_d  = grant_q;
        grant_d = 2'b00;
        last_d  = grant_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 16'd0;
      rem_q   <= 17'd0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign grant    = grant_q;
  assign ch_done  = done_q;
  assign rb_start = start_q;
  assign rb_addr  = addr_q;
  assign rb_size  = size_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rd_sched.sv
// Bench for rd_sched: a read-block responder, an output monitor and a transaction-level
// model that expands each granted request into its expected list of read commands.
module tb_rd_sched;
  localparam int MAX_CHUNK = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [15:0] req_size0 = '0, req_size1 = '0;
  logic [1:0]  grant, ch_done;
  logic        rb_start;
  logic [31:0] rb_addr;
  logic [15:0] rb_size;
  logic        rb_busy, rb_done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] cmd_addr_q[$];
  logic [15:0] cmd_size_q[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  done_log[$];
  int          start_eps, busy_bad, ncyc, grant_cyc, done_cyc;

  logic [31:0] exp_addr[$];
  logic [15:0] exp_size[$];
  int          last_served = 1;
  int          spurious_req = 0, spurious_ack = 0;
  bit          slow = 1'b0;

  rd_sched #(.MAX_CHUNK(MAX_CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_size0(req_size0), .req_size1(req_size1),
    .grant(grant), .ch_done(ch_done),
    .rb_start(rb_start), .rb_addr(rb_addr), .rb_size(rb_size),
    .rb_busy(rb_busy), .rb_done(rb_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected read commands for one transfer, straight from the chunking rules.
  task automatic model_cmds(input logic [31:0] addr, input int size);
    int rem, c;
    logic [31:0] a;
    rem = ((size + 3) / 4) * 4;
    a   = {addr[31:2], 2'b00};
`ifdef RD_SCHED_SPLIT_EN
    while (rem > 0) begin
      c = (rem < MAX_CHUNK) ? rem : MAX_CHUNK;
      exp_addr.push_back(a);
      exp_size.push_back(16'(c));
      a   = a + 32'(c);
      rem = rem - c;
    end
`else
    if (rem > 0) begin
      exp_addr.push_back(a);
      exp_size.push_back((rem == 65536) ? 16'hFFFC : 16'(rem));
    end
`endif
  endtask

  // Read-block model: accepts a start after 0-2 cycles, busy for 1-4 cycles, then pulses done.
  initial begin : responder
    int st, lat, hold;
    st = 0; lat = 0; hold = 0;
    rb_busy = 1'b0; rb_done = 1'b0;
    forever begin
      @(negedge clk);
      rb_done = 1'b0;
      if (!rst_n) begin
        rb_busy = 1'b0;
        st = 0;
      end else if (st == 1) begin
        if (lat > 1) lat--;
        else begin
          rb_done = 1'b1;
          rb_busy = 1'b0;
          st = 0;
        end
      end else if (spurious_ack != spurious_req) begin
        rb_done = 1'b1;
        spurious_ack++;
      end else if (rb_start === 1'b1) begin
        if (hold > 0) hold--;
        else begin
          cmd_addr_q.push_back(rb_addr);
          cmd_size_q.push_back(rb_size);
          rb_busy = 1'b1;
          lat  = slow ? 8 : int'($urandom_range(1, 4));
          hold = int'($urandom_range(0, 2));
          st = 1;
        end
      end
    end
  end

  initial begin : monitor
    logic [1:0] pg;
    logic       ps;
    pg = 2'b00; ps = 1'b0;
    ncyc = 0; start_eps = 0; busy_bad = 0; grant_cyc = 0; done_cyc = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (grant !== 2'b00 && pg === 2'b00) begin
        grant_log.push_back(grant);
        grant_cyc = ncyc;
      end
      if (ch_done !== 2'b00) begin
        done_log.push_back(ch_done);
        done_cyc = ncyc;
      end
      if (rb_start === 1'b1 && ps !== 1'b1) start_eps++;
      if (busy !== (grant != 2'b00)) busy_bad++;
      pg = grant;
      ps = rb_start;
    end
  end

  task automatic run_txn(input logic [1:0] mask, input logic [31:0] a0, input int s0,
                         input logic [31:0] a1, input int s1, input string tag);
    int cb, gb, db, eb, bb, waited;
    int order[$];
    logic [1:0] got;
    exp_addr.delete();
    exp_size.delete();
    cb = cmd_addr_q.size(); gb = grant_log.size(); db = done_log.size();
    eb = start_eps; bb = busy_bad;
    if (mask == 2'b11) begin
      order.push_back(1 - last_served);
      order.push_back(last_served);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    foreach (order[i]) model_cmds(order[i] == 0 ? a0 : a1, order[i] == 0 ? s0 : s1);

    req_addr0 = a0; req_size0 = 16'(s0);
    req_addr1 = a1; req_size1 = 16'(s1);
    req0 = mask[0]; req1 = mask[1];
    got = 2'b00; waited = 0;
    while (got != mask && waited < 20000) begin
      @(negedge clk);
      waited++;
      if (ch_done[0] === 1'b1) begin req0 = 1'b0; got[0] = 1'b1; end
      if (ch_done[1] === 1'b1) begin req1 = 1'b0; got[1] = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check({tag, "_served"}, 64'(got), 64'(mask));
    repeat (3) @(negedge clk);

    check({tag, "_ncmd"}, 64'(cmd_addr_q.size() - cb), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (cb + i < cmd_addr_q.size()) begin
        check({tag, "_addr"}, 64'(cmd_addr_q[cb + i]), 64'(exp_addr[i]));
        check({tag, "_size"}, 64'(cmd_size_q[cb + i]), 64'(exp_size[i]));
      end
    end
    check({tag, "_starts"}, 64'(start_eps - eb), 64'(exp_addr.size()));
    check({tag, "_ngrant"}, 64'(grant_log.size() - gb), 64'(order.size()));
    check({tag, "_ndone"}, 64'(done_log.size() - db), 64'(order.size()));
    foreach (order[i]) begin
      if (gb + i < grant_log.size())
        check({tag, "_grant"}, 64'(grant_log[gb + i]), 64'(2'b01 << order[i]));
      if (db + i < done_log.size())
        check({tag, "_done"}, 64'(done_log[db + i]), 64'(2'b01 << order[i]));
    end
    check({tag, "_busy"}, 64'(busy_bad - bb), 64'd0);
    last_served = order[order.size() - 1];
    $display("txn %-12s mask=%b size0=%0d size1=%0d cmds=%0d", tag, mask, s0, s1, exp_addr.size());
  endtask

  initial begin : main
    int waited, db, dbs;
    logic [1:0] m;
    logic [31:0] ra0, ra1;
    int rs0, rs1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({grant, ch_done, rb_start, rb_addr, rb_size, busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(2'b11, 32'h0000_3000, 4, 32'h0000_4000, 4, "rr_both");
    run_txn(2'b01, 32'h0000_1002, 8, 32'h0, 0, "req0_unalign");
    run_txn(2'b10, 32'h0, 0, 32'h0000_2000, 150, "req1_150");
    run_txn(2'b01, 32'h0000_5000, 0, 32'h0, 0, "size0");
    check("size0_latency", 64'(done_cyc - grant_cyc), 64'd2);

    // rb_done while idle must not start or finish anything
    dbs = done_log.size();
    spurious_req++;
    repeat (4) @(negedge clk);
    check("spurious_idle", 64'({grant, busy, rb_start}), 64'd0);
    check("spurious_no_done", 64'(done_log.size() - dbs), 64'd0);

    // reset while the read block is busy
    slow = 1'b1;
    req_addr0 = 32'h0000_8000; req_size0 = 16'd200; req0 = 1'b1;
    waited = 0;
    while (!(rb_busy === 1'b1 && rb_start === 1'b0 && grant === 2'b01) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rst_reached_wait", 64'(waited < 200), 64'd1);
    db = done_log.size();
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({grant, ch_done, rb_start, rb_addr, rb_size, busy}), 64'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold", 64'({grant, ch_done, rb_start, rb_addr, rb_size, busy}), 64'd0);
    rst_n = 1'b1;
    slow = 1'b0;
    last_served = 1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'(done_log.size() - db), 64'd0);
    run_txn(2'b11, 32'h0000_9004, 20, 32'h0000_A000, 12, "post_rst_rr");
    run_txn(2'b01, 32'h0000_B001, 70, 32'h0, 0, "post_rst_r0");

    run_txn(2'b01, 32'hFFFF_FFC0, 150, 32'h0, 0, "wrap");
    run_txn(2'b10, 32'h0, 0, 32'h0000_0103, 65535, "size_ffff");
    run_txn(2'b01, 32'h0000_0010, 65533, 32'h0, 0, "size_fffd");
    run_txn(2'b11, 32'h0000_0020, 1, 32'h0000_0030, 0, "tiny_both");

    for (int k = 0; k < 30; k++) begin
      m   = 2'($urandom_range(1, 3));
      ra0 = $urandom;
      ra1 = $urandom;
      if (k % 7 == 0) ra0 = 32'hFFFF_FF00 | ($urandom & 32'hFF);
      rs0 = int'($urandom_range(0, 400));
      rs1 = int'($urandom_range(0, 400));
      if ($urandom_range(0, 9) == 0) rs1 = 0;
      run_txn(m, ra0, rs0, ra1, rs1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
